// File: rtl/tri_agetag_alloc.sv
// In-order age-tag allocator: hands out wrapping SIZE-bit tags from tail, retires from head.
// Optional flush support is compiled in with `define TRI_AGETAG_FLUSH_EN.
module tri_agetag_alloc #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_val,
  output logic            alloc_rdy,
  output logic [SIZE-1:0] alloc_tag,
  input  logic [1:0]      retire_cnt,
  input  logic            flush_val,
  input  logic [SIZE-1:0] flush_tag,
  output logic            oldest_val,
  output logic [SIZE-1:0] oldest_tag,
  output logic [SIZE-1:0] count
);

  localparam logic [SIZE-1:0] W_DEPTH = SIZE'(DEPTH);
  localparam logic [SIZE-1:0] W_ONE   = SIZE'(1);

  logic [SIZE-1:0] r_head, r_tail, r_cnt;
  logic [SIZE-1:0] w_rc, w_ret, w_head_nxt, w_cnt_ret;
  logic [SIZE-1:0] w_tail_nxt, w_cnt_nxt, w_acc_inc;
  logic            w_space, w_acc;

  assign w_space    = (r_cnt < W_DEPTH);
  assign w_rc       = SIZE'(retire_cnt);
  // Retire saturates at the number of live tags.
  assign w_ret      = (w_rc > r_cnt) ? r_cnt : w_rc;
  assign w_head_nxt = r_head + w_ret;
  assign w_cnt_ret  = r_cnt - w_ret;
  assign w_acc      = alloc_val & alloc_rdy;
  assign w_acc_inc  = SIZE'(w_acc);

`ifdef TRI_AGETAG_FLUSH_EN
  logic [SIZE-1:0] w_off;
  logic            w_flush_hit;

  assign alloc_rdy   = w_space & ~flush_val;
  // Offset of the flush tag from the post-retire head; a tag retired this
  // cycle wraps to a large offset and so falls outside the window.
  assign w_off       = flush_tag - w_head_nxt;
  assign w_flush_hit = flush_val & (w_off < w_cnt_ret);

  always_comb begin
    w_tail_nxt = r_tail + w_acc_inc;
    w_cnt_nxt  = w_cnt_ret + w_acc_inc;
    if (w_flush_hit) begin
      w_tail_nxt = flush_tag + W_ONE;
      w_cnt_nxt  = w_off + W_ONE;
    end
  end
`else
  logic w_flush_unused;

  assign alloc_rdy      = w_space;
  assign w_flush_unused = ^{flush_val, flush_tag};

  always_comb begin
    w_tail_nxt = r_tail + w_acc_inc;
    w_cnt_nxt  = w_cnt_ret + w_acc_inc;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign alloc_tag  = r_tail;
  assign oldest_val = (r_cnt != '0);
  assign oldest_tag = r_head;
  assign count      = r_cnt;

endmodule
